multiword_add_seq: RTL and testbench
====================================

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 Parameter N, default 8, word width in bits (N >= 2).
REQ-002 Parameter WORDS, default 4, number of words per operand (WORDS >= 2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  begins one multi-word addition; sampled only in IDLE.
REQ-006 cin  input  1  initial carry-in; sampled together with start.
REQ-007 in_valid  input  1  a_word/b_word are valid this cycle.
REQ-008 in_ready  output  1  block accepts a word pair this cycle.
REQ-009 a_word  input  N  operand A slice; least significant word first.
REQ-010 b_word  input  N  operand B slice; least significant word first.
REQ-011 out_valid  output  1  out_sum holds a valid result word.
REQ-012 out_ready  input  1  downstream accepts out_sum this cycle.
REQ-013 out_sum  output  N  result word.
REQ-014 out_last  output  1  out_sum is word WORDS-1.
REQ-015 out_cout  output  1  final carry-out; meaningful only while out_valid && out_last.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, RUN, FLUSH.
REQ-018 IDLE -> RUN on start: carry register := cin, word counter := 0; start ignored in RUN/FLUSH.
REQ-019 in_ready = (state == RUN) && (!out_valid || out_ready).
REQ-020 Accept = in_valid && in_ready; one word pair is consumed per accept.
REQ-021 On accept: out_sum <= (a_word + b_word + carry) mod 2^N; carry <= bit N of that sum; out_valid <= 1; out_last <= (counter == WORDS-1); counter increments.
REQ-022 Latency: result word appears on out_sum exactly 1 cycle after its accept.
REQ-023 out_cout <= carry-out of word WORDS-1, registered with it; 0 on all other words.
REQ-024 Output holds stable (out_sum/out_last/out_cout unchanged, out_valid high) while out_valid && !out_ready.
REQ-025 out_valid clears on out_valid && out_ready with no simultaneous accept; simultaneous hand-off and accept loads the new word with no bubble.
REQ-026 Accept of word WORDS-1 moves RUN -> FLUSH; no further input is accepted in FLUSH (in_ready = 0).
REQ-027 FLUSH -> IDLE on out_valid && out_ready && out_last; busy drops that same edge.
REQ-028 Counter width is clog2(WORDS); it never wraps past WORDS-1 within one operation.
REQ-029 Back-to-back operations are allowed: start may be asserted in the first IDLE cycle.
REQ-030 The adder performs no sign interpretation; operands are unsigned.

Reset
REQ-031 rst asynchronously forces state = IDLE, counter = 0, carry = 0, out_valid = 0, out_sum = 0, out_last = 0, out_cout = 0.
REQ-032 Reset asserted mid-operation discards the operation; no partial out_last is ever emitted afterwards.
REQ-033 After reset release, the block is idle (in_ready = 0, busy = 0) until start.

Structure
REQ-034 Shared package mwadd_pkg holds the state enum type and the default N/WORDS constants.
REQ-035 Single sub-module: ripple_carry_adder of width N+1, operands {a_word,1'b1} and {b_word,carry}; Sum[N:1] is the word sum and Cout is the word carry.
REQ-036 No other arithmetic operators are used on the datapath; control logic is in this module.

Verification (N=8, WORDS=4, out_ready=1 unless stated)
REQ-037 cin=0, A=0x000000FF, B=0x00000001 -> out_sum 0x00, 0x01, 0x00, 0x00; out_last on word 4; out_cout=0.
REQ-038 cin=0, A=0xFFFFFFFF, B=0x00000001 -> all words 0x00; out_cout=1 on last word; busy low the cycle after the last hand-off.
REQ-039 cin=1, A=B=0 -> out_sum 0x01, 0x00, 0x00, 0x00; out_cout=0.
REQ-040 out_ready held low 3 cycles after word 1 -> in_ready=0, out_sum steady at word-1 value; resumes with no lost or duplicated word.
REQ-041 start pulsed during RUN -> ignored; counter and result unaffected.
REQ-042 rst asserted after word 2 accepted -> all outputs 0 immediately; fresh operation then yields correct 4-word result.

Source files
------------

// File: rtl/mwadd_pkg.sv
// Shared types and default sizing for the sequential multi-word adder.
package mwadd_pkg;

  localparam int DEF_N     = 8;
  localparam int DEF_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/multiword_add_seq_if.sv
// Word-stream bus of the multi-word adder: operand input, result output and status.
interface multiword_add_seq_if import mwadd_pkg::*; #(
  parameter int N = DEF_N
);
  logic         start;
  logic         cin;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a_word;
  logic [N-1:0] b_word;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_last;
  logic         out_cout;
  logic         busy;

  modport master (
    output start, cin, in_valid, a_word, b_word, out_ready,
    input  in_ready, out_valid, out_sum, out_last, out_cout, busy
  );

  modport slave (
    input  start, cin, in_valid, a_word, b_word, out_ready,
    output in_ready, out_valid, out_sum, out_last, out_cout, busy
  );
endinterface

// File: rtl/multiword_add_seq_ripple_carry_adder.sv
// Plain ripple-carry adder built from per-bit full adders, no carry-in pin.
module ripple_carry_adder #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_fa
      assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[W];
endmodule

// File: rtl/multiword_add_seq.sv
// Adds two WORDS-word operands one N-bit slice per accept, LS word first,
// propagating the carry between slices and streaming result words out.
module multiword_add_seq import mwadd_pkg::*; #(
  parameter int N     = DEF_N,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                clk,
  input  logic                rst,
  multiword_add_seq_if.slave  bus
);
  localparam int             CW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(WORDS - 1);

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg, count_next;
  logic           carry_reg, carry_next;
  logic           out_valid_reg, out_valid_next;
  logic [N-1:0]   sum_reg, sum_next;
  logic           last_reg, last_next;
  logic           cout_reg, cout_next;

  logic           in_ready;
  logic           accept;
  logic           handoff;
  logic           is_last;
  logic [N:0]     add_sum;
  logic           add_cout;
  logic           unused_lsb;

  // The forced 1 in bit 0 turns the stored carry into the carry into bit 1.
  ripple_carry_adder #(.W(N + 1)) u_adder (
    .a    ({bus.a_word, 1'b1}),
    .b    ({bus.b_word, carry_reg}),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign unused_lsb = add_sum[0];

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    carry_next     = carry_reg;
    out_valid_next = out_valid_reg;
    sum_next       = sum_reg;
    last_next      = last_reg;
    cout_next      = cout_reg;

    in_ready = (state_reg == RUN) && (!out_valid_reg || bus.out_ready);
    accept   = in_ready && bus.in_valid;
    handoff  = out_valid_reg && bus.out_ready;
    is_last  = (count_reg == LAST_IDX);

    if (handoff) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          carry_next = bus.cin;
          count_next = '0;
        end
      end
      RUN: begin
        if (accept) begin
          out_valid_next = 1'b1;
          sum_next       = add_sum[N:1];
          last_next      = is_last;
          cout_next      = is_last & add_cout;
          carry_next     = add_cout;
          if (is_last) begin
            state_next = FLUSH;
            count_next = '0;
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (handoff && last_reg) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      carry_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      last_reg      <= 1'b0;
      cout_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      carry_reg     <= carry_next;
      out_valid_reg <= out_valid_next;
      sum_reg       <= sum_next;
      last_reg      <= last_next;
      cout_reg      <= cout_next;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = sum_reg;
  assign bus.out_last  = last_reg;
  assign bus.out_cout  = cout_reg;
  assign bus.busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench: fixed vectors, stall/start/reset corner cases, random ops vs. a wide-add model.
module tb_multiword_add_seq;
  localparam int N     = 8;
  localparam int WORDS = 4;

  logic clk;
  logic rst;

  multiword_add_seq_if #(.N(N)) bus ();

  multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  int total;
  int passed;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h want=%0h", name, got, exp);
  endtask

  // mode: 0 ready always, 1 random valid/ready, 2 stall on word 1,
  //       3 start pulse mid-run, 4 reset after two words accepted
  task automatic run_op(input logic c, input logic [31:0] a, input logic [31:0] b,
                        input int mode, output logic [31:0] sum, output logic cout,
                        output logic [3:0] lasts, output logic [3:0] couts);
    int          in_idx;
    int          out_idx;
    int          stall;
    int          cyc;
    bit          in_adv;
    logic [31:0] sh;
    logic [32:0] model;
    in_idx = 0; out_idx = 0; stall = 0; cyc = 0;
    sum = '0; cout = 1'b0; lasts = '0; couts = '0;
    model = {1'b0, a} + {1'b0, b} + 33'(c);
    bus.start = 1'b1;
    bus.cin   = c;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.cin   = 1'b0;
    while (out_idx < WORDS && cyc < 200) begin
      cyc++;
      bus.in_valid  = (in_idx < WORDS) && (mode != 1 || $urandom_range(0, 2) != 0);
      sh            = a >> (8 * in_idx);
      bus.a_word    = sh[7:0];
      sh            = b >> (8 * in_idx);
      bus.b_word    = sh[7:0];
      bus.out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mode == 2 && out_idx == 1 && stall < 3) bus.out_ready = 1'b0;
      bus.start     = (mode == 3 && in_idx == 1);
      bus.cin       = ~c;
      @(negedge clk);
      if (mode == 2 && out_idx == 1 && stall < 3) begin
        stall++;
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_sum", 64'(bus.out_sum), 64'(model[15:8]));
      end
      in_adv = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        sum[out_idx*8 +: 8] = bus.out_sum;
        lasts[out_idx]      = bus.out_last;
        couts[out_idx]      = bus.out_cout;
        if (bus.out_last) cout = bus.out_cout;
        out_idx++;
      end
      @(posedge clk); #1;
      if (in_adv) in_idx++;
      if (mode == 4 && in_idx == 2) begin
        rst = 1'b1;
        #1;
        check("rst_outputs",
              64'({bus.out_valid, bus.out_sum, bus.out_last, bus.out_cout, bus.busy, bus.in_ready}),
              64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    bus.cin      = 1'b0;
    if (mode != 4) check("op_done", 64'(out_idx), 64'(WORDS));
  endtask

  task automatic verify(input string name, input logic [31:0] exp_sum, input logic exp_cout,
                        input logic [31:0] sum, input logic cout,
                        input logic [3:0] lasts, input logic [3:0] couts);
    check({name, "_sum"}, 64'(sum), 64'(exp_sum));
    check({name, "_cout"}, 64'(cout), 64'(exp_cout));
    check({name, "_last_flags"}, 64'(lasts), 64'(4'b1000));
    check({name, "_cout_flags"}, 64'(couts), 64'({exp_cout, 3'b000}));
    check({name, "_busy_after"}, 64'(bus.busy), 64'd0);
    $display("op %s: sum=%08h cout=%0b (expect %08h/%0b)", name, sum, cout, exp_sum, exp_cout);
  endtask

  vec_t        vecs [7];
  logic [31:0] got_sum;
  logic        got_cout;
  logic [3:0]  got_lasts;
  logic [3:0]  got_couts;
  logic [32:0] model;
  logic [31:0] ra, rb;
  logic        rc;
  int          seen_valid;

  initial begin
    total = 0; passed = 0;
    vecs[0] = '{1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[2] = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000001, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{1'b0, 32'h12345678, 32'h87654321, 32'h99999999, 1'b0};
    vecs[5] = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    vecs[6] = '{1'b1, 32'h7F7F7F7F, 32'h00808080, 32'h80000000, 1'b0};

    rst = 1'b1;
    bus.start = 1'b0; bus.cin = 1'b0; bus.in_valid = 1'b0;
    bus.a_word = '0; bus.b_word = '0; bus.out_ready = 1'b1;
    #1;
    check("reset_outputs",
          64'({bus.out_valid, bus.out_sum, bus.out_last, bus.out_cout, bus.busy, bus.in_ready}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_reset", 64'({bus.busy, bus.in_ready, bus.out_valid}), 64'd0);
    bus.in_valid = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].cin, vecs[i].a, vecs[i].b, 0, got_sum, got_cout, got_lasts, got_couts);
      verify($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout,
             got_sum, got_cout, got_lasts, got_couts);
    end

    for (int m = 2; m <= 3; m++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      model = {1'b0, ra} + {1'b0, rb} + 33'(rc);
      run_op(rc, ra, rb, m, got_sum, got_cout, got_lasts, got_couts);
      verify(m == 2 ? "stall" : "start_mid", model[31:0], model[32],
             got_sum, got_cout, got_lasts, got_couts);
    end

    run_op(1'b1, 32'hFFFFFFFF, 32'h00000000, 4, got_sum, got_cout, got_lasts, got_couts);
    $display("op reset_mid: aborted after two words");
    seen_valid = 0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) seen_valid++;
    end
    check("no_output_after_reset", 64'(seen_valid), 64'd0);
    @(posedge clk); #1;
    run_op(1'b0, 32'h01FF02FE, 32'h00010203, 0, got_sum, got_cout, got_lasts, got_couts);
    verify("post_reset", 32'h02000501, 1'b0, got_sum, got_cout, got_lasts, got_couts);

    for (int t = 0; t < 20; t++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      if (t % 5 == 0) ra = 32'hFFFFFFFF - rb;
      model = {1'b0, ra} + {1'b0, rb} + 33'(rc);
      run_op(rc, ra, rb, 1, got_sum, got_cout, got_lasts, got_couts);
      verify($sformatf("rand%0d", t), model[31:0], model[32],
             got_sum, got_cout, got_lasts, got_couts);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
